// File: rtl/execute_stage.sv
// execute_stage
// Execute stage of a five-stage RISC-V pipeline. Holds the ID/EX register,
// the rs1/rs2 forwarding muxes, the ALU, the beq-style branch resolver, and
// the EX/MEM register.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   StallE, FlushE         hazard-unit hold / bubble requests for ID/EX
//   *_D                    decode-stage control, addresses and data
//   ForwardAE, ForwardBE   operand forward selects (00/11 reg, 01 WB, 10 MEM)
//   Result_W               writeback-stage result for forwarding
//   Rs1_E, Rs2_E, RD_E     E-stage register addresses to the hazard unit
//   ResultSrc_E            load-in-E flag
//   PCSrc_E, PCTarget_E    branch taken and branch target
//   *_M                    EX/MEM register outputs to the memory stage
module execute_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              RegWrite_D,
  input  logic              MemWrite_D,
  input  logic              Branch_D,
  input  logic              ALUSrc_D,
  input  logic              ResultSrc_D,
  input  logic [2:0]        ALUControl_D,
  input  logic [REG_AW-1:0] RD_D,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [XLEN-1:0]   RD1_D,
  input  logic [XLEN-1:0]   RD2_D,
  input  logic [XLEN-1:0]   Imm_Ext_D,
  input  logic [XLEN-1:0]   PC_D,
  input  logic [XLEN-1:0]   PCPlus4_D,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [XLEN-1:0]   Result_W,
  output logic [REG_AW-1:0] Rs1_E,
  output logic [REG_AW-1:0] Rs2_E,
  output logic [REG_AW-1:0] RD_E,
  output logic              ResultSrc_E,
  output logic              PCSrc_E,
  output logic [XLEN-1:0]   PCTarget_E,
  output logic              RegWrite_M,
  output logic              MemWrite_M,
  output logic              ResultSrc_M,
  output logic [REG_AW-1:0] RD_M,
  output logic [XLEN-1:0]   ALUResult_M,
  output logic [XLEN-1:0]   WriteData_M,
  output logic [XLEN-1:0]   PCPlus4_M
);

  // ID/EX register
  logic              valid_e_q, valid_e_d;
  logic              reg_write_e_q, reg_write_e_d;
  logic              mem_write_e_q, mem_write_e_d;
  logic              branch_e_q, branch_e_d;
  logic              alu_src_e_q, alu_src_e_d;
  logic              result_src_e_q, result_src_e_d;
  logic [2:0]        alu_control_e_q, alu_control_e_d;
  logic [REG_AW-1:0] rd_e_q, rd_e_d;
  logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
  logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
  logic [XLEN-1:0]   rd1_e_q, rd1_e_d;
  logic [XLEN-1:0]   rd2_e_q, rd2_e_d;
  logic [XLEN-1:0]   imm_ext_e_q, imm_ext_e_d;
  logic [XLEN-1:0]   pc_e_q, pc_e_d;
  logic [XLEN-1:0]   pc_plus4_e_q, pc_plus4_e_d;

  // EX/MEM register
  logic              reg_write_m_q, reg_write_m_d;
  logic              mem_write_m_q, mem_write_m_d;
  logic              result_src_m_q, result_src_m_d;
  logic [REG_AW-1:0] rd_m_q, rd_m_d;
  logic [XLEN-1:0]   alu_result_m_q, alu_result_m_d;
  logic [XLEN-1:0]   write_data_m_q, write_data_m_d;
  logic [XLEN-1:0]   pc_plus4_m_q, pc_plus4_m_d;

  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   write_data_e;
  logic [XLEN-1:0]   src_b;
  logic [XLEN-1:0]   alu_result;
  logic              zero;

  // Flush wins over stall; a flushed entry is an all-zero bubble.
  always_comb begin
    valid_e_d       = valid_e_q;
    reg_write_e_d   = reg_write_e_q;
    mem_write_e_d   = mem_write_e_q;
    branch_e_d      = branch_e_q;
    alu_src_e_d     = alu_src_e_q;
    result_src_e_d  = result_src_e_q;
    alu_control_e_d = alu_control_e_q;
    rd_e_d          = rd_e_q;
    rs1_e_d         = rs1_e_q;
    rs2_e_d         = rs2_e_q;
    rd1_e_d         = rd1_e_q;
    rd2_e_d         = rd2_e_q;
    imm_ext_e_d     = imm_ext_e_q;
    pc_e_d          = pc_e_q;
    pc_plus4_e_d    = pc_plus4_e_q;
    if (FlushE) begin
      valid_e_d       = 1'b0;
      reg_write_e_d   = 1'b0;
      mem_write_e_d   = 1'b0;
      branch_e_d      = 1'b0;
      alu_src_e_d     = 1'b0;
      result_src_e_d  = 1'b0;
      alu_control_e_d = '0;
      rd_e_d          = '0;
      rs1_e_d         = '0;
      rs2_e_d         = '0;
      rd1_e_d         = '0;
      rd2_e_d         = '0;
      imm_ext_e_d     = '0;
      pc_e_d          = '0;
      pc_plus4_e_d    = '0;
    end else if (!StallE) begin
      valid_e_d       = 1'b1;
      reg_write_e_d   = RegWrite_D;
      mem_write_e_d   = MemWrite_D;
      branch_e_d      = Branch_D;
      alu_src_e_d     = ALUSrc_D;
      result_src_e_d  = ResultSrc_D;
      alu_control_e_d = ALUControl_D;
      rd_e_d          = RD_D;
      rs1_e_d         = Rs1_D;
      rs2_e_d         = Rs2_D;
      rd1_e_d         = RD1_D;
      rd2_e_d         = RD2_D;
      imm_ext_e_d     = Imm_Ext_D;
      pc_e_d          = PC_D;
      pc_plus4_e_d    = PCPlus4_D;
    end
  end

  // Forwarding: 10 takes our own EX/MEM result, 01 the writeback result.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = Result_W;
      2'b10:   src_a = alu_result_m_q;
      default: src_a = rd1_e_q;
    endcase
    case (ForwardBE)
      2'b01:   write_data_e = Result_W;
      2'b10:   write_data_e = alu_result_m_q;
      default: write_data_e = rd2_e_q;
    endcase
    src_b = alu_src_e_q ? imm_ext_e_q : write_data_e;
  end

  always_comb begin
    case (alu_control_e_q)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero       = (alu_result == '0);
  assign PCSrc_E    = valid_e_q & branch_e_q & zero;
  assign PCTarget_E = pc_e_q + imm_ext_e_q;

  // A stalled or invalid E entry sends a bubble to M so it never writes.
  always_comb begin
    reg_write_m_d  = 1'b0;
    mem_write_m_d  = 1'b0;
    result_src_m_d = 1'b0;
    rd_m_d         = '0;
    alu_result_m_d = '0;
    write_data_m_d = '0;
    pc_plus4_m_d   = '0;
    if (!StallE && valid_e_q) begin
      reg_write_m_d  = reg_write_e_q;
      mem_write_m_d  = mem_write_e_q;
      result_src_m_d = result_src_e_q;
      rd_m_d         = rd_e_q;
      alu_result_m_d = alu_result;
      write_data_m_d = write_data_e;
      pc_plus4_m_d   = pc_plus4_e_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e_q       <= 1'b0;
      reg_write_e_q   <= 1'b0;
      mem_write_e_q   <= 1'b0;
      branch_e_q      <= 1'b0;
      alu_src_e_q     <= 1'b0;
      result_src_e_q  <= 1'b0;
      alu_control_e_q <= '0;
      rd_e_q          <= '0;
      rs1_e_q         <= '0;
      rs2_e_q         <= '0;
      rd1_e_q         <= '0;
      rd2_e_q         <= '0;
      imm_ext_e_q     <= '0;
      pc_e_q          <= '0;
      pc_plus4_e_q    <= '0;
      reg_write_m_q   <= 1'b0;
      mem_write_m_q   <= 1'b0;
      result_src_m_q  <= 1'b0;
      rd_m_q          <= '0;
      alu_result_m_q  <= '0;
      write_data_m_q  <= '0;
      pc_plus4_m_q    <= '0;
    end else begin
      valid_e_q       <= valid_e_d;
      reg_write_e_q   <= reg_write_e_d;
      mem_write_e_q   <= mem_write_e_d;
      branch_e_q      <= branch_e_d;
      alu_src_e_q     <= alu_src_e_d;
      result_src_e_q  <= result_src_e_d;
      alu_control_e_q <= alu_control_e_d;
      rd_e_q          <= rd_e_d;
      rs1_e_q         <= rs1_e_d;
      rs2_e_q         <= rs2_e_d;
      rd1_e_q         <= rd1_e_d;
      rd2_e_q         <= rd2_e_d;
      imm_ext_e_q     <= imm_ext_e_d;
      pc_e_q          <= pc_e_d;
      pc_plus4_e_q    <= pc_plus4_e_d;
      reg_write_m_q   <= reg_write_m_d;
      mem_write_m_q   <= mem_write_m_d;
      result_src_m_q  <= result_src_m_d;
      rd_m_q          <= rd_m_d;
      alu_result_m_q  <= alu_result_m_d;
      write_data_m_q  <= write_data_m_d;
      pc_plus4_m_q    <= pc_plus4_m_d;
    end
  end

  assign Rs1_E       = rs1_e_q;
  assign Rs2_E       = rs2_e_q;
  assign RD_E        = rd_e_q;
  assign ResultSrc_E = result_src_e_q;
  assign RegWrite_M  = reg_write_m_q;
  assign MemWrite_M  = mem_write_m_q;
  assign ResultSrc_M = result_src_m_q;
  assign RD_M        = rd_m_q;
  assign ALUResult_M = alu_result_m_q;
  assign WriteData_M = write_data_m_q;
  assign PCPlus4_M   = pc_plus4_m_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk, rst, StallE, FlushE;
  logic        RegWrite_D, MemWrite_D, Branch_D, ALUSrc_D, ResultSrc_D;
  logic [2:0]  ALUControl_D;
  logic [4:0]  RD_D, Rs1_D, Rs2_D;
  logic [31:0] RD1_D, RD2_D, Imm_Ext_D, PC_D, PCPlus4_D;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] Result_W;
  logic [4:0]  Rs1_E, Rs2_E, RD_E;
  logic        ResultSrc_E, PCSrc_E;
  logic [31:0] PCTarget_E;
  logic        RegWrite_M, MemWrite_M, ResultSrc_M;
  logic [4:0]  RD_M;
  logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M;

  execute_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D), .Branch_D(Branch_D),
    .ALUSrc_D(ALUSrc_D), .ResultSrc_D(ResultSrc_D), .ALUControl_D(ALUControl_D),
    .RD_D(RD_D), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_Ext_D(Imm_Ext_D), .PC_D(PC_D),
    .PCPlus4_D(PCPlus4_D), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .Result_W(Result_W), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E),
    .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
    .RD_M(RD_M), .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
    .PCPlus4_M(PCPlus4_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction sitting in E and the record sitting in M.
  typedef struct packed {
    logic        valid, rw, mw, br, asrc, rsrc;
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] a, b, imm, pc, pc4;
  } instr_t;

  typedef struct packed {
    logic        rw, mw, rsrc;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
  } mrec_t;

  instr_t e_m = '0;
  mrec_t  m_m = '0;
  bit     chk_en = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  function automatic logic [31:0] pick(logic [1:0] s, logic [31:0] r, logic [31:0] w,
                                       logic [31:0] m);
    if (s == 2'b01) return w;
    if (s == 2'b10) return m;
    return r;
  endfunction

  function automatic logic [31:0] alu_f(logic [2:0] op, logic [31:0] x, logic [31:0] y);
    int signed sx, sy;
    sx = x;
    sy = y;
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd5: return (sx < sy) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ex_wd(instr_t e, logic [1:0] fb, logic [31:0] w,
                                        logic [31:0] m);
    return pick(fb, e.b, w, m);
  endfunction

  function automatic logic [31:0] ex_alu(instr_t e, logic [1:0] fa, logic [1:0] fb,
                                         logic [31:0] w, logic [31:0] m);
    logic [31:0] sa, sb;
    sa = pick(fa, e.a, w, m);
    sb = e.asrc ? e.imm : ex_wd(e, fb, w, m);
    return alu_f(e.op, sa, sb);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e_m <= '0;
      m_m <= '0;
    end else begin
      if (StallE || !e_m.valid) m_m <= '0;
      else m_m <= {e_m.rw, e_m.mw, e_m.rsrc, e_m.rd,
                   ex_alu(e_m, ForwardAE, ForwardBE, Result_W, m_m.alu),
                   ex_wd(e_m, ForwardBE, Result_W, m_m.alu), e_m.pc4};
      if (FlushE) e_m <= '0;
      else if (!StallE)
        e_m <= {1'b1, RegWrite_D, MemWrite_D, Branch_D, ALUSrc_D, ResultSrc_D,
                ALUControl_D, RD_D, Rs1_D, Rs2_D, RD1_D, RD2_D, Imm_Ext_D, PC_D, PCPlus4_D};
    end
  end

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] res;
      res = ex_alu(e_m, ForwardAE, ForwardBE, Result_W, m_m.alu);
      check("e_regs", {Rs1_E, Rs2_E, RD_E, ResultSrc_E},
            {e_m.rs1, e_m.rs2, e_m.rd, e_m.rsrc});
      check("branch", {PCSrc_E, PCTarget_E},
            {e_m.valid & e_m.br & (res == 32'd0), e_m.pc + e_m.imm});
      check("m_regs", {RegWrite_M, MemWrite_M, ResultSrc_M, RD_M, ALUResult_M,
                       WriteData_M, PCPlus4_M}, m_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    RegWrite_D = 0; MemWrite_D = 0; Branch_D = 0; ALUSrc_D = 0; ResultSrc_D = 0;
    ALUControl_D = 0; RD_D = 0; Rs1_D = 0; Rs2_D = 0;
    RD1_D = 0; RD2_D = 0; Imm_Ext_D = 0; PC_D = 0; PCPlus4_D = 0;
  endtask

  task automatic rand_dec();
    RegWrite_D = 1'($urandom); MemWrite_D = 1'($urandom); Branch_D = 1'($urandom);
    ALUSrc_D = 1'($urandom); ResultSrc_D = 1'($urandom); ALUControl_D = 3'($urandom);
    RD_D = 5'($urandom); Rs1_D = 5'($urandom); Rs2_D = 5'($urandom);
    RD1_D = $urandom; RD2_D = ($urandom_range(0, 3) == 0) ? RD1_D : $urandom;
    Imm_Ext_D = $urandom; PC_D = $urandom; PCPlus4_D = $urandom;
  endtask

  logic [31:0] va [5] = '{32'hF0F0_1234, 32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFFE, 32'h1};
  logic [31:0] vb [5] = '{32'h0FF0_5678, 32'h0000_0001, 32'hFFFF_FFF9, 32'h0000_0003, 32'h1};
  logic [2:0]  vo [5] = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

  initial begin
    rst = 1; StallE = 0; FlushE = 0; ForwardAE = 0; ForwardBE = 0; Result_W = 0;
    clear_dec();

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      rand_dec();
      StallE = 1'($urandom); FlushE = 1'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); Result_W = $urandom;
      tick();
      chk_en = 1;
      check("rst_outputs", {Rs1_E, Rs2_E, RD_E, ResultSrc_E, PCSrc_E, PCTarget_E,
                            RegWrite_M, MemWrite_M, ResultSrc_M, RD_M, ALUResult_M,
                            WriteData_M, PCPlus4_M}, 160'd0);
    end
    rst = 0; StallE = 0; FlushE = 0; ForwardAE = 0; ForwardBE = 0; Result_W = 0;
    clear_dec();
    RegWrite_D = 1; RD1_D = 32'h10; RD2_D = 32'h22; RD_D = 5'd1;
    tick();
    clear_dec();
    #1;
    check("first_in_e_rd", {27'd0, RD_E}, 32'd1);
    check("first_not_in_m", {31'd0, RegWrite_M}, 32'd0);
    tick();
    check("first_in_m", {RegWrite_M, RD_M, ALUResult_M}, {1'b1, 5'd1, 32'h32});

    // Add then dependent sub via EX/MEM forward
    RegWrite_D = 1; RD1_D = 5; RD2_D = 7; ALUControl_D = 3'b000; RD_D = 5'd3;
    tick();
    clear_dec();
    RegWrite_D = 1; Rs1_D = 5'd3; RD2_D = 1; ALUControl_D = 3'b001; RD_D = 5'd4;
    tick();
    check("add_result", ALUResult_M, 32'd12);
    ForwardAE = 2'b10;
    clear_dec();
    tick();
    check("sub_fwd_ex", {RD_M, ALUResult_M}, {5'd4, 32'd11});
    ForwardAE = 2'b00;

    // slt with WB forward
    RegWrite_D = 1; RD1_D = 0; RD2_D = 32'h55; ALUControl_D = 3'b101; RD_D = 5'd5;
    tick();
    ForwardBE = 2'b01; Result_W = 32'hFFFF_FFFF;
    clear_dec();
    RegWrite_D = 1; RD1_D = 32'hFFFF_FFFF; ALUControl_D = 3'b101; RD_D = 5'd6;
    tick();
    check("slt_0_lt_m1", {RD_M, ALUResult_M}, {5'd5, 32'd0});
    Result_W = 32'd0;
    clear_dec();
    tick();
    check("slt_m1_lt_0", {RD_M, ALUResult_M}, {5'd6, 32'd1});
    ForwardBE = 2'b00;

    // Branch taken / not taken / flushed
    Branch_D = 1; RD1_D = 9; RD2_D = 9; ALUControl_D = 3'b001; PC_D = 32'h100; Imm_Ext_D = 32'h20;
    tick();
    RD2_D = 8;
    #1;
    check("beq_taken", {PCSrc_E, PCTarget_E}, {1'b1, 32'h120});
    tick();
    RD2_D = 9; FlushE = 1;
    #1;
    check("beq_not_taken", {PCSrc_E, PCTarget_E}, {1'b0, 32'h120});
    tick();
    FlushE = 0;
    clear_dec();
    #1;
    check("beq_flushed", {PCSrc_E, RD_E, PCTarget_E}, {1'b0, 5'd0, 32'd0});

    // Stall for two cycles
    RegWrite_D = 1; Rs1_D = 5'd7; RD_D = 5'd9; RD1_D = 2; RD2_D = 3;
    tick();
    StallE = 1;
    clear_dec();
    RegWrite_D = 1; MemWrite_D = 1; Rs1_D = 5'd11; RD_D = 5'd12; RD1_D = 100; RD2_D = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_hold_e", {Rs1_E, RD_E}, {5'd7, 5'd9});
      check("stall_bubble_m", {RegWrite_M, MemWrite_M, RD_M}, 7'd0);
      Rs2_D = 5'(k + 1);
    end
    StallE = 0;
    tick();
    check("stall_release", {RegWrite_M, RD_M, ALUResult_M, Rs1_E}, {1'b1, 5'd9, 32'd5, 5'd11});

    // Flush and stall together
    FlushE = 1; StallE = 1;
    clear_dec();
    tick();
    check("flush_stall_e", {RD_E, PCSrc_E}, 6'd0);
    check("flush_stall_m", {MemWrite_M, RegWrite_M}, 2'd0);
    FlushE = 0; StallE = 0;
    tick();
    check("bubble_to_m", {MemWrite_M, RegWrite_M, RD_M}, 7'd0);

    // Remaining ALU codes, checked by the model each cycle
    for (int i = 0; i < 5; i++) begin
      clear_dec();
      RegWrite_D = 1; RD_D = 5'(i + 20); RD1_D = va[i]; RD2_D = vb[i]; ALUControl_D = vo[i];
      tick();
    end
    clear_dec();
    tick();
    tick();
    check("and_or_pin", ALUResult_M, 32'd0);

    // Mid-stream reset
    RegWrite_D = 1; RD_D = 5'd13; RD1_D = 1;
    tick();
    tick();
    rst = 1;
    tick();
    check("midrst", {RD_E, RD_M, RegWrite_M, ALUResult_M}, 43'd0);
    rst = 0;

    // Random vectors with occasional stall/flush
    for (int i = 0; i < 80; i++) begin
      rand_dec();
      StallE = ($urandom_range(0, 5) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); Result_W = $urandom;
      tick();
    end
    tick();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage RISC-V pipeline: the ID/EX pipeline register, the operand-forwarding muxes driven by the hazard unit's ForwardAE/ForwardBE, the ALU, the branch resolver and the EX/MEM pipeline register. It consumes decode-stage outputs and hazard-unit forward selects. It supplies Rs1_E/Rs2_E back to the hazard unit and RegWrite_M/RD_M to both the hazard unit and the memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register-address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- StallE  in  1  hold ID/EX contents
- FlushE  in  1  load bubble into ID/EX
- RegWrite_D, MemWrite_D, Branch_D, ALUSrc_D, ResultSrc_D  in  1 each  decode control
- ALUControl_D  in  3  ALU op
- RD_D, Rs1_D, Rs2_D  in  REG_AW  register addresses
- RD1_D, RD2_D, Imm_Ext_D, PC_D, PCPlus4_D  in  XLEN  decode data
- ForwardAE, ForwardBE  in  2  forward selects from hazard unit
- Result_W  in  XLEN  writeback result
- Rs1_E, Rs2_E, RD_E  out  REG_AW  E-stage addresses to hazard unit
- ResultSrc_E  out  1  load-in-E flag for load-use detection
- PCSrc_E  out  1  branch taken
- PCTarget_E  out  XLEN  branch target
- RegWrite_M, MemWrite_M, ResultSrc_M  out  1  M-stage control
- RD_M  out  REG_AW  M-stage destination
- ALUResult_M, WriteData_M, PCPlus4_M  out  XLEN  M-stage data

## Operation
- ID/EX register holds all decode inputs plus a valid bit (valid_E).
- Priority on each clock edge:
  - rst: all registers clear to 0.
  - Else FlushE: ID/EX clears to a bubble (every field 0, valid_E=0).
  - Else StallE: ID/EX holds its contents.
  - Else ID/EX loads decode inputs with valid_E=1.
- FlushE has priority over StallE when both are asserted.
- SrcA mux on ForwardAE:
  - 00: RD1_E
  - 01: Result_W
  - 10: ALUResult_M, the block's own EX/MEM output
  - 11: RD1_E
- ForwardBE selects the forwarded rs2 value (WriteData_E) by the same encoding, with RD2_E as the 00/11 source.
- SrcB = ALUSrc_E ? Imm_Ext_E : WriteData_E.
- ALU ops, all modulo 2^XLEN:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt, signed, result 0 or 1
  - any other code: result 0
- Zero = (ALU result == 0).
- PCSrc_E = valid_E & Branch_E & Zero, i.e. beq semantics.
- PCTarget_E = PC_E + Imm_Ext_E, carry discarded.
- EX/MEM register:
  - rst: clears to 0.
  - Else StallE asserted or valid_E=0: loads a bubble (RegWrite_M=MemWrite_M=ResultSrc_M=0; RD_M and data fields 0).
  - Else loads RegWrite_E, MemWrite_E, ResultSrc_E, RD_E, ALU result, WriteData_E and PCPlus4_E.
- A bubble never asserts RegWrite_M or MemWrite_M.
- Rs1_E, Rs2_E, RD_E and ResultSrc_E are driven directly from ID/EX.

## Timing
- Reset value of every output: 0. PCSrc_E is 0 because valid_E=0.
- Decode inputs sampled at edge N appear on the E outputs after edge N.
- The corresponding M outputs appear after edge N+1. Latency is 2 edges from decode to M.
- PCSrc_E and PCTarget_E are combinational from ID/EX and forwarded operands, valid within the E cycle.
- Forwarding selects are combinational inputs, consumed in the same cycle.
- Back-to-back dependent ALU ops: forward path 10 returns the previous result with zero stall cycles.
- Stall of k cycles: ID/EX holds for k edges and EX/MEM inserts k bubbles. The held instruction issues to M on the first edge with StallE=0.
- rst asserted mid-stream: both registers clear on that edge, discarding in-flight instructions.

## Test plan
- Reset: rst high for 2 cycles with random inputs -> all outputs 0, PCSrc_E=0. Release rst -> first instruction reaches M 2 edges later.
- Add with EX forward: RD1_D=5, RD2_D=7, ALUControl_D=000, RD_D=3. Next instruction has ForwardAE=10, RD2_D=1, ALUControl_D=001 -> ALUResult_M=12, then 11.
- WB forward and slt: ForwardBE=01, Result_W=0xFFFFFFFF, RD1=0, ALUControl=101, ALUSrc=0 -> ALUResult_M=0. Then swap operands (RD1=0xFFFFFFFF, Result_W=0) -> 1.
- Branch: Branch_D=1, RD1=RD2=9, sub, PC_D=0x100, Imm=0x20 -> PCSrc_E=1 and PCTarget_E=0x120 in the E cycle. RD2=8 -> PCSrc_E=0. The same instruction flushed before reaching E -> PCSrc_E=0.
- Stall: StallE=1 for 2 cycles with decode inputs changing -> Rs1_E/RD_E unchanged and M receives 2 bubbles (RegWrite_M=0). The held instruction's result appears in M one edge after StallE falls.
- Flush with stall: FlushE=1 and StallE=1 on the same edge -> ID/EX becomes a bubble (RD_E=0, PCSrc_E=0). The next M output is a bubble with MemWrite_M=0.
